// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port among NREQ requesters.
// Grants are combinational; the write command to the file is registered.
module regfile_write_arbiter #(
    parameter int NREQ = 3,
    parameter int DW   = 10,
    parameter int AW   = 2
) (
    input  logic             CLKb,
    input  logic             RSTb,
    input  logic             hold,
    input  logic [NREQ-1:0]  req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]  req_ready,
    output logic [DW-1:0]    D,
    output logic             ENW,
    output logic [AW-1:0]    WRA,
    output logic [1:0]       gnt_id
);

    logic [1:0]    r_ptr;
    logic [DW-1:0] r_d;
    logic          r_enw;
    logic [AW-1:0] r_wra;
    logic [1:0]    r_gnt;

    logic          w_hi_any;
    logic          w_lo_any;
    logic [1:0]    w_hi;
    logic [1:0]    w_lo;
    logic          w_any;
    logic [1:0]    w_win;
    logic          w_grant;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic [1:0]    w_ptr_nxt;

    // Lowest valid index at/above ptr wins; else lowest valid index below ptr.
    always_comb begin
        w_hi_any = 1'b0;
        w_lo_any = 1'b0;
        w_hi     = '0;
        w_lo     = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (i >= int'(r_ptr))) begin
                w_hi_any = 1'b1;
                w_hi     = 2'(i);
            end
            if (req_valid[i] && (i < int'(r_ptr))) begin
                w_lo_any = 1'b1;
                w_lo     = 2'(i);
            end
        end
        w_any = w_hi_any | w_lo_any;
        w_win = w_hi_any ? w_hi : w_lo;
    end

    always_comb begin
        w_addr = '0;
        w_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == 2'(i)) begin
                w_addr = req_addr[i*AW +: AW];
                w_data = req_data[i*DW +: DW];
            end
        end
    end

    assign w_grant   = w_any & ~hold & RSTb;
    assign w_ptr_nxt = (w_win == 2'(NREQ - 1)) ? 2'd0 : w_win + 2'd1;
    assign req_ready = w_grant ? (NREQ'(1) << w_win) : '0;

    always_ff @(posedge CLKb or negedge RSTb) begin
        if (!RSTb) begin
            r_ptr <= '0;
            r_d   <= '0;
            r_enw <= 1'b0;
            r_wra <= '0;
            r_gnt <= '0;
        end else if (w_grant) begin
            r_ptr <= w_ptr_nxt;
            r_d   <= w_data;
            r_enw <= 1'b1;
            r_wra <= w_addr;
            r_gnt <= w_win;
        end else begin
            r_enw <= 1'b0;
        end
    end

    assign D      = r_d;
    assign ENW    = r_enw;
    assign WRA    = r_wra;
    assign gnt_id = r_gnt;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a behavioural register file.
// Expected values are hand-derived from the round-robin rules.
module tb_regfile_write_arbiter;

    logic        CLKb;
    logic        RSTb;
    logic        hold;
    logic [2:0]  req_valid;
    logic [5:0]  req_addr;
    logic [29:0] req_data;
    logic [2:0]  req_ready;
    logic [9:0]  D;
    logic        ENW;
    logic [1:0]  WRA;
    logic [1:0]  gnt_id;

    logic [9:0]  rf [4];
    logic [9:0]  snap;
    int          n_cmp;
    int          n_err;

    regfile_write_arbiter #(.NREQ(3), .DW(10), .AW(2)) dut (
        .CLKb      (CLKb),
        .RSTb      (RSTb),
        .hold      (hold),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .D         (D),
        .ENW       (ENW),
        .WRA       (WRA),
        .gnt_id    (gnt_id)
    );

    initial CLKb = 1'b0;
    always #5 CLKb = ~CLKb;

    // Downstream register file: no reset, writes on ENW at the rising edge.
    always @(posedge CLKb) begin
        if (ENW) rf[WRA] <= D;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLKb);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 4; i++) rf[i] = 10'h000;
        RSTb      = 1'b0;
        hold      = 1'b0;
        req_valid = 3'b000;
        req_addr  = '0;
        req_data  = '0;

        // 1: reset with all valid
        #12;
        req_valid = 3'b111;
        #1;
        chk("rst_enw", ENW, 0);
        chk("rst_ready", req_ready, 3'b000);
        chk("rst_d", D, 0);
        chk("rst_wra", WRA, 0);
        chk("rst_gnt", gnt_id, 0);
        @(negedge CLKb);
        RSTb = 1'b1;
        #1;
        chk("rel_ready", req_ready, 3'b001);
        req_valid = 3'b000;

        // 2: single requester 1
        req_valid = 3'b010;
        req_addr  = 6'b00_10_00;
        req_data  = {10'h000, 10'h155, 10'h000};
        #1;
        chk("t2_ready", req_ready, 3'b010);
        tick();
        req_valid = 3'b000;
        chk("t2_enw", ENW, 1);
        chk("t2_wra", WRA, 2);
        chk("t2_d", D, 10'h155);
        chk("t2_gnt", gnt_id, 1);
        tick();
        chk("t2_enw_off", ENW, 0);
        chk("t2_d_hold", D, 10'h155);
        chk("t2_rf2", rf[2], 10'h155);

        // move ptr from 2 back to 0 with a lone req2 grant
        req_valid = 3'b100;
        #1;
        chk("t3_pre_ready", req_ready, 3'b100);
        tick();
        req_valid = 3'b000;
        tick();

        // 3: all valid continuously
        req_valid = 3'b111;
        req_addr  = {2'd2, 2'd1, 2'd0};
        req_data  = {10'h222, 10'h111, 10'h0F0};
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("t3_ready", req_ready, 3'b001 << (k % 3));
            tick();
            chk("t3_enw", ENW, 1);
            chk("t3_gnt", gnt_id, k % 3);
        end
        req_valid = 3'b000;
        tick();
        chk("t3_enw_off", ENW, 0);
        chk("t3_rf1", rf[1], 10'h111);

        // 4: hold for three cycles with req0 and req2 pending
        hold      = 1'b1;
        req_valid = 3'b101;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t4_hold_ready", req_ready, 3'b000);
            tick();
            chk("t4_hold_enw", ENW, 0);
        end
        hold = 1'b0;
        #1;
        chk("t4_ready0", req_ready, 3'b001);
        tick();
        chk("t4_gnt0", gnt_id, 0);
        chk("t4_enw0", ENW, 1);
        req_valid = 3'b100;
        #1;
        chk("t4_ready2", req_ready, 3'b100);
        tick();
        chk("t4_gnt2", gnt_id, 2);
        req_valid = 3'b000;
        tick();

        // 5: reset while a write to reg1 is pending
        snap      = rf[1];
        req_valid = 3'b100;
        req_addr  = {2'd1, 2'd0, 2'd0};
        req_data  = {10'h2A5, 10'h000, 10'h000};
        #1;
        chk("t5_ready", req_ready, 3'b100);
        tick();
        req_valid = 3'b000;
        chk("t5_enw_pend", ENW, 1);
        #2;
        RSTb = 1'b0;
        #1;
        chk("t5_enw_drop", ENW, 0);
        chk("t5_d_rst", D, 0);
        tick();
        chk("t5_rf1", rf[1], snap);
        @(negedge CLKb);
        RSTb      = 1'b1;
        req_valid = 3'b110;
        #1;
        chk("t5_ptr0", req_ready, 3'b010);
        req_valid = 3'b000;

        // 6: two requesters target reg3
        req_valid = 3'b011;
        req_addr  = {2'd0, 2'd3, 2'd3};
        req_data  = {10'h000, 10'h3FF, 10'h0AA};
        #1;
        chk("t6_ready0", req_ready, 3'b001);
        tick();
        chk("t6_d0", D, 10'h0AA);
        chk("t6_wra0", WRA, 3);
        req_valid = 3'b010;
        #1;
        chk("t6_ready1", req_ready, 3'b010);
        tick();
        chk("t6_enw1", ENW, 1);
        chk("t6_d1", D, 10'h3FF);
        req_valid = 3'b000;
        tick();
        chk("t6_rf3", rf[3], 10'h3FF);
        chk("t6_enw_off", ENW, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
